verdict_collector: RTL and testbench
====================================

// Module: verdict_collector
// PURPOSE
//  Downstream stage of the compiled RTLola monitor (topEntity). Samples the monitor's output streams
//  whenever any output_N_aktv is high and tags each sample with a free-running cycle timestamp.
//  Buffers the records in a FIFO and drains them over a ready/valid stream to the host/trace interface.
//  Counts records lost to overflow.
// PARAMETERS
//  NUM_OUT  3   number of monitor output streams
//  DATA_W   64  width of each output value (signed, passed through untouched)
//  TS_W     32  timestamp counter width
//  DEPTH    16  FIFO depth in records; power of two, >= 2
// PORTS
//  clk          in   1               clock
//  rst          in   1               reset: asynchronous, active-high
//  en           in   1               global enable; same signal that drives the monitor
//  out_data     in   NUM_OUT*DATA_W  monitor outputs; stream k occupies bits [k*DATA_W +: DATA_W]
//  out_aktv     in   NUM_OUT         per-stream active flags from the monitor
//  m_valid      out  1               record available on m_*
//  m_ready      in   1               consumer accepts the record
//  m_ts         out  TS_W            timestamp of the record
//  m_aktv       out  NUM_OUT         active mask of the record
//  m_data       out  NUM_OUT*DATA_W  values; inactive lanes are zero
//  fifo_level   out  $clog2(DEPTH)+1 current record count
//  overflow_cnt out  16              records dropped; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async assert, sync release): ts_cnt=0, FIFO empty, m_valid=0, m_ts/m_aktv/m_data=0,
//   fifo_level=0, overflow_cnt=0. Reset mid-operation discards all buffered records immediately.
//  ts_cnt: increments by 1 on every clk edge with en=1; wraps from 2^TS_W-1 to 0 with no flag; holds when en=0.
//  Capture: on an edge with en=1 and |out_aktv, push {ts_cnt (pre-increment), out_aktv, masked out_data}.
//   Lanes with aktv=0 are written as 0. en=0 suppresses capture.
//  Pop: m_valid && m_ready at an edge. FIFO is first-word-fall-through.
//  Latency: a record captured at edge N gives m_valid=1 after edge N (1 cycle), when the FIFO was empty.
//  m_* outputs are stable while m_valid=1 and m_ready=0.
//  Full: a capture with level==DEPTH and no pop in the same cycle is dropped; overflow_cnt += 1 (saturating).
//  Full + simultaneous pop: the push is accepted and level stays DEPTH; no drop.
//  Empty + simultaneous push: m_valid=0 that cycle; the record appears next cycle (no bypass).
//  fifo_level: registered; updated in the same edge as the push/pop.
//  Pointers: $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty; wrap is natural modulo.
// CONFIGURATION
//  VERDICT_CHANGE_FILTER_EN defined: a capture is suppressed when {aktv, masked data} equals the last
//   accepted record. Suppressed captures do not touch overflow_cnt. The last-record register is cleared
//   by reset, so the first capture after reset always passes.
//  Not defined: every active cycle is captured; no comparison logic is built.
// STRUCTURE
//  Package verdict_pkg: NUM_OUT/DATA_W/TS_W defaults, typedef verdict_rec_t {ts, aktv, data},
//   REC_W localparam, and function mask_lanes().
//  Sub-module verdict_fifo: generic synchronous FWFT FIFO (WIDTH, DEPTH). It provides push, pop, full,
//   empty and level. The top level holds the timestamp counter, capture/filter logic, overflow counter
//   and m_* unpacking.
// TESTING
//  1 Reset, en=1, idle 10 cycles -> m_valid=0; at the 10th edge ts_cnt=10 (probe); overflow_cnt=0.
//  2 aktv=3'b101, data=(1,9,1) at ts 5 -> next cycle m_valid=1, m_ts=5, m_aktv=101, m_data=(1,0,1);
//     m_ready=1 -> m_valid=0.
//  3 m_ready=0, 20 consecutive captures with DEPTH=16 -> fifo_level=16, overflow_cnt=4; drain yields
//     ts in order, first 16 only.
//  4 Full FIFO, m_ready=1 and capture in the same cycle -> level stays 16, overflow_cnt unchanged,
//     new record last out.
//  5 ts_cnt preloaded to 32'hFFFFFFFF via force, capture 2 consecutive cycles -> m_ts=FFFFFFFF
//     then 0.
//  6 FILTER_EN: identical aktv/data on 3 cycles, then changed -> 2 records; without the macro -> 4 records.
//     Assert rst with 5 buffered records -> m_valid=0 immediately.

Source files
------------

// File: rtl/verdict_collector_pkg.sv
// verdict_pkg: shared widths, record layout and lane masking for the verdict collector.
package verdict_pkg;
  localparam int NUM_OUT = 3;
  localparam int DATA_W = 64;
  localparam int TS_W = 32;
  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [NUM_OUT-1:0] aktv;
    logic [NUM_OUT*DATA_W-1:0] data;
  } verdict_rec_t;
  localparam int REC_W = $bits(verdict_rec_t);
  function automatic logic [NUM_OUT*DATA_W-1:0] mask_lanes(
    input logic [NUM_OUT*DATA_W-1:0] d,
    input logic [NUM_OUT-1:0] a
  );
    logic [NUM_OUT*DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_OUT; k++) r[k*DATA_W +: DATA_W] = a[k] ? d[k*DATA_W +: DATA_W] : '0;
    return r;
  endfunction
endpackage

// File: rtl/verdict_collector_fifo.sv
// verdict_fifo: synchronous first-word-fall-through FIFO with a registered fill level.
module verdict_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  // a pop frees the slot, so a push into a full FIFO is still accepted
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/verdict_collector.sv
// verdict_collector: timestamps active monitor outputs and buffers them for a ready/valid drain.
// Optional VERDICT_CHANGE_FILTER_EN drops captures identical to the last accepted record.
module verdict_collector
  import verdict_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_OUT*DATA_W-1:0] out_data,
  input  logic [NUM_OUT-1:0]        out_aktv,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [TS_W-1:0]           m_ts,
  output logic [NUM_OUT-1:0]        m_aktv,
  output logic [NUM_OUT*DATA_W-1:0] m_data,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [15:0]               overflow_cnt
);
  logic [TS_W-1:0] ts_cnt;
  logic [NUM_OUT*DATA_W-1:0] masked;
  verdict_rec_t rec_in, rec_out;
  logic cap, push, pop, full, empty, dup;
  assign masked = mask_lanes(out_data, out_aktv);
  assign rec_in = '{ts: ts_cnt, aktv: out_aktv, data: masked};
  assign cap = en && |out_aktv;
  assign pop = m_valid && m_ready;
  assign push = cap && !dup;
`ifdef VERDICT_CHANGE_FILTER_EN
  // cleared aktv never matches a real capture, so the first one after reset passes
  logic [NUM_OUT+NUM_OUT*DATA_W-1:0] last;
  assign dup = {out_aktv, masked} == last;
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= '0;
    else if (push && (!full || pop)) last <= {out_aktv, masked};
`else
  assign dup = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ts_cnt <= '0;
      overflow_cnt <= '0;
    end else begin
      if (en) ts_cnt <= ts_cnt + TS_W'(1);
      if (push && full && !pop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
    end
  verdict_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(rec_in), .pop(pop),
    .dout(rec_out), .full(full), .empty(empty), .level(fifo_level)
  );
  assign m_valid = !empty;
  assign m_ts = m_valid ? rec_out.ts : '0;
  assign m_aktv = m_valid ? rec_out.aktv : '0;
  assign m_data = m_valid ? rec_out.data : '0;
endmodule

// File: tb/tb_verdict_collector.sv
// tb_verdict_collector: directed checks of capture, ordering, overflow, wrap, filter and reset.
module tb_verdict_collector;
  logic clk = 1'b0;
  logic rst, en, m_ready, m_valid;
  logic [191:0] out_data, m_data;
  logic [2:0] out_aktv, m_aktv;
  logic [31:0] m_ts;
  logic [4:0] fifo_level;
  logic [15:0] overflow_cnt;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  verdict_collector dut (
    .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
    .m_valid(m_valid), .m_ready(m_ready), .m_ts(m_ts), .m_aktv(m_aktv), .m_data(m_data),
    .fifo_level(fifo_level), .overflow_cnt(overflow_cnt)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; out_aktv = '0; out_data = '0; m_ready = 1'b0;
    step(); step();
    chk("rst_valid", 192'(m_valid), 192'(0));
    chk("rst_ts", 192'(m_ts), 192'(0));
    chk("rst_aktv", 192'(m_aktv), 192'(0));
    chk("rst_data", m_data, 192'(0));
    chk("rst_level", 192'(fifo_level), 192'(0));
    chk("rst_ovf", 192'(overflow_cnt), 192'(0));
    rst = 1'b0; en = 1'b1;
    repeat (10) step();
    chk("idle_ts_cnt", 192'(dut.ts_cnt), 192'(10));
    chk("idle_valid", 192'(m_valid), 192'(0));
    chk("idle_ovf", 192'(overflow_cnt), 192'(0));
    do_reset();
    repeat (5) step();
    out_aktv = 3'b101; out_data = {64'd1, 64'd9, 64'd1};
    step();
    out_aktv = '0;
    chk("cap_valid", 192'(m_valid), 192'(1));
    chk("cap_ts", 192'(m_ts), 192'(5));
    chk("cap_aktv", 192'(m_aktv), 192'(3'b101));
    chk("cap_data", m_data, {64'd1, 64'd0, 64'd1});
    m_ready = 1'b1;
    step();
    chk("cap_popped", 192'(m_valid), 192'(0));
    m_ready = 1'b0;
    do_reset();
    out_aktv = 3'b001;
    for (int i = 0; i < 20; i++) begin
      out_data = 192'(i + 100);
      step();
    end
    out_aktv = '0;
    chk("ovf_level", 192'(fifo_level), 192'(16));
    chk("ovf_cnt", 192'(overflow_cnt), 192'(4));
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain_valid", 192'(m_valid), 192'(1));
      chk("ovf_drain_ts", 192'(m_ts), 192'(i));
      step();
    end
    chk("ovf_drained", 192'(m_valid), 192'(0));
    chk("ovf_level0", 192'(fifo_level), 192'(0));
    m_ready = 1'b0;
    do_reset();
    out_aktv = 3'b001;
    for (int i = 0; i < 16; i++) begin
      out_data = 192'(i + 200);
      step();
    end
    chk("full_level", 192'(fifo_level), 192'(16));
    m_ready = 1'b1; out_data = 192'(999);
    step();
    out_aktv = '0;
    chk("fullpp_level", 192'(fifo_level), 192'(16));
    chk("fullpp_ovf", 192'(overflow_cnt), 192'(0));
    for (int i = 0; i < 15; i++) begin
      chk("fullpp_ts", 192'(m_ts), 192'(i + 1));
      step();
    end
    chk("fullpp_last_ts", 192'(m_ts), 192'(16));
    chk("fullpp_last_data", m_data, 192'(999));
    step();
    chk("fullpp_empty", 192'(m_valid), 192'(0));
    m_ready = 1'b0;
    do_reset();
    force dut.ts_cnt = 32'hFFFF_FFFF;
    #1 release dut.ts_cnt;
    out_aktv = 3'b001; out_data = 192'(1);
    step();
    out_data = 192'(2);
    step();
    out_aktv = '0;
    chk("wrap_ts_hi", 192'(m_ts), 192'(32'hFFFF_FFFF));
    m_ready = 1'b1;
    step();
    chk("wrap_valid", 192'(m_valid), 192'(1));
    chk("wrap_ts_zero", 192'(m_ts), 192'(0));
    step();
    m_ready = 1'b0;
    chk("wrap_empty", 192'(m_valid), 192'(0));
    do_reset();
    out_aktv = 3'b011; out_data = {64'd7, 64'd5, 64'd3};
    step();
    out_data = {64'd8, 64'd5, 64'd3};
    step(); step();
    out_data = {64'd8, 64'd5, 64'd4};
    step();
    out_aktv = '0;
`ifdef VERDICT_CHANGE_FILTER_EN
    chk("filter_level", 192'(fifo_level), 192'(2));
`else
    chk("filter_level", 192'(fifo_level), 192'(4));
`endif
    chk("filter_first_data", m_data, {64'd0, 64'd5, 64'd3});
    chk("filter_ovf", 192'(overflow_cnt), 192'(0));
    do_reset();
    out_aktv = 3'b001;
    for (int i = 0; i < 5; i++) begin
      out_data = 192'(i + 50);
      step();
    end
    out_aktv = '0;
    chk("pre_rst_level", 192'(fifo_level), 192'(5));
    chk("pre_rst_valid", 192'(m_valid), 192'(1));
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 192'(m_valid), 192'(0));
    chk("async_rst_level", 192'(fifo_level), 192'(0));
    chk("async_rst_ts", 192'(m_ts), 192'(0));
    step();
    rst = 1'b0;
    step();
    chk("post_rst_valid", 192'(m_valid), 192'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
